// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO slave: register offsets,
// edge-capture encodings and the bus address width.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] REG_DATA    = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] REG_DIR     = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] REG_IRQMASK = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] REG_EDGECAP = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] REG_OUTSET  = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] REG_OUTCLR  = 3'd5;
  localparam logic [GPIO_ADDR_W-1:0] REG_OUTVAL  = 3'd6;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_bidir_irq_if.sv
// Avalon-MM slave bundle for the GPIO block.
// Ports: address, chipselect, write_n, writedata, readdata.
interface gpio_bidir_irq_if;
  import gpio_pkg::*;

  logic [GPIO_ADDR_W-1:0] address;
  logic                   chipselect;
  logic                   write_n;
  logic [31:0]            writedata;
  logic [31:0]            readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/gpio_sync.sv
// Resettable multi-flop synchroniser for pin-facing inputs.
// Ports: clk, reset (sync, active-high), d (async in), q (synced).
module gpio_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        stg[k] <= '0;
    end else begin
      stg[0] <= d;
      for (int k = 1; k < SYNC_STAGES; k++)
        stg[k] <= stg[k-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bidir_irq.sv
// Parametrised bidirectional GPIO slave with edge-latched masked IRQ.
// Ports: clk, reset, bus (Avalon slave), irq, bidir_port (pins).
module gpio_bidir_irq
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 28,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bidir_irq_if.slave  bus,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam int BLANK_N = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(BLANK_N + 1);

  typedef logic [WIDTH-1:0] vec_t;

  vec_t data_out;
  vec_t data_dir;
  vec_t irq_mask;
  vec_t edgecap;
  vec_t pin_s;
  vec_t pin_p;
  vec_t edge_raw;
  vec_t edge_hit;
  vec_t w1c;
  vec_t wd;
  vec_t rd_vec;

  logic [CNT_W-1:0] blank_cnt;
  logic [31:0]      rd_word;

  logic wr;
  logic hit_data;
  logic hit_dir;
  logic hit_mask;
  logic hit_cap;
  logic hit_set;
  logic hit_clr;
  logic unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  assign hit_data = wr & (bus.address == REG_DATA);
  assign hit_dir  = wr & (bus.address == REG_DIR);
  assign hit_mask = wr & (bus.address == REG_IRQMASK);
  assign hit_cap  = wr & (bus.address == REG_EDGECAP);
  assign hit_set  = wr & (bus.address == REG_OUTSET);
  assign hit_clr  = wr & (bus.address == REG_OUTCLR);

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bidir_port),
    .q     (pin_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
  end

  always_comb begin
    edge_raw = pin_s ^ pin_p;
    if (EDGE_TYPE == EDGE_RISING)
      edge_raw = pin_s & ~pin_p;
    else if (EDGE_TYPE == EDGE_FALLING)
      edge_raw = ~pin_s & pin_p;
  end

  // Synchroniser and previous-sample flops restart at 0, so pins
  // already high would look like fresh edges until they settle.
  assign edge_hit = (blank_cnt != '0) ? '0 : edge_raw;
  assign w1c      = hit_cap ? wd : '0;

  always_comb begin
    rd_vec = '0;
    case (bus.address)
      REG_DATA:    rd_vec = pin_s;
      REG_DIR:     rd_vec = data_dir;
      REG_IRQMASK: rd_vec = irq_mask;
      REG_EDGECAP: rd_vec = edgecap;
      REG_OUTVAL:  rd_vec = data_out;
      default:     rd_vec = '0;
    endcase
    rd_word              = '0;
    rd_word[WIDTH-1:0]   = rd_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= '0;
      data_dir     <= DIR_RESET;
      irq_mask     <= '0;
      edgecap      <= '0;
      pin_p        <= '0;
      blank_cnt    <= CNT_W'(BLANK_N);
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      unique case (1'b1)
        hit_data: data_out <= wd;
        hit_set:  data_out <= data_out | wd;
        hit_clr:  data_out <= data_out & ~wd;
        default:  ;
      endcase
      if (hit_dir)
        data_dir <= wd;
      if (hit_mask)
        irq_mask <= wd;
      // A new edge outranks a same-cycle clear.
      edgecap <= (edgecap & ~w1c) | edge_hit;
      pin_p   <= pin_s;
      if (blank_cnt != '0)
        blank_cnt <= blank_cnt - CNT_W'(1);
      bus.readdata <= rd_word;
      irq          <= |(edgecap & irq_mask);
    end
  end

endmodule
